flow_ctrl_unit: RTL

- Control-flow controller that drives the program sequencer's jump inputs.
- Holds a DEPTH-entry return-address stack for call/ret and a hardware loop counter for counted loops.
- Sits between instruction decode and the program sequencer.
- Drives jmp, jmp_nz, dont_jmp and an 8-bit jump target for the widened-address sequencer revision.

---
 rtl/flow_ctrl_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/flow_ctrl_unit.sv
// Control-flow unit: return-address stack for call/ret plus a single hardware
// loop counter. The jump outputs are combinational so the sequencer can redirect
// in the same cycle as the strobe. All state updates on the following clock edge.
module flow_ctrl_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic          call,
  input  logic          ret,
  input  logic          loop_load,
  input  logic [7:0]    loop_cnt,
  input  logic          loop_end,
  input  logic [3:0]    target,
  input  logic          clr_err,
  output logic          jmp,
  output logic          jmp_nz,
  output logic          dont_jmp,
  output logic [AW-1:0] jmp_addr,
  output logic [4:0]    depth,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] stack [DEPTH];
  logic [4:0]    sp;
  logic [7:0]    lc;

  logic [AW-1:0] call_addr;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;
  logic          loop_sel;
  logic          ovf_set;
  logic          unf_set;

  assign depth     = sp;
  assign full      = (sp == 5'(DEPTH));
  assign empty     = (sp == '0);
  assign call_addr = AW'({target, 4'h0});

  // When full, the push is not taken, so truncating sp here never aliases.
  assign push_idx  = IW'(sp);
  assign top_idx   = IW'(sp - 5'd1);

  // Strobe arbitration: call beats ret, ret beats loop_end.
  always_comb begin
    do_push  = call & ~full;
    ovf_set  = call & full;
    do_pop   = ~call & ret & ~empty;
    unf_set  = ~call & ret & empty;
    loop_sel = ~call & ~ret & loop_end;
  end

  // Combinational jump request to the sequencer, forced quiet during reset.
  always_comb begin
    jmp      = 1'b0;
    jmp_nz   = 1'b0;
    dont_jmp = 1'b0;
    jmp_addr = '0;
    if (!reset) begin
      if (do_push) begin
        jmp      = 1'b1;
        jmp_addr = call_addr;
      end else if (do_pop) begin
        jmp      = 1'b1;
        jmp_addr = stack[top_idx];
      end else if (loop_sel) begin
        jmp_nz   = 1'b1;
        jmp_addr = call_addr;
        dont_jmp = (lc <= 8'd1);
      end
    end
  end

  // Return-address storage; popped entries are left in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (do_push) begin
      stack[push_idx] <= pc + AW'(1);
    end
  end

  // Stack pointer and sticky error flags; a new error beats clr_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (do_push)     sp <= sp + 5'd1;
      else if (do_pop) sp <= sp - 5'd1;
      ovf <= ovf_set | (ovf & ~clr_err);
      unf <= unf_set | (unf & ~clr_err);
    end
  end

  // Loop counter; a load overrides the decrement from a coincident loop_end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lc <= '0;
    end else if (loop_load) begin
      lc <= loop_cnt;
    end else if (loop_sel) begin
      lc <= (lc > 8'd1) ? lc - 8'd1 : '0;
    end
  end

endmodule
